// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch controller: assembles a 32-bit little-endian word from four byte reads
// on a variable-latency memory port, with a one-entry last-word buffer for stall replays.
module rom_fetch_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_enable_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o,
    input  logic              invalidate_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_data_i,
    input  logic              mem_valid_i
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_re_q, mem_re_d;

    logic [ADDR_W-1:0] req_base_s;
    logic              hit_s;
    logic              last_byte_s;
    logic              timeout_s;

    assign req_base_s  = addr_i & ~ADDR_W'(3);
    assign hit_s       = buf_valid_q && (req_base_s == buf_addr_q);
    assign last_byte_s = (byte_cnt_q == 2'd3);
    assign timeout_s   = (wait_cnt_q == WCNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (r_enable_i) begin
                    state_d = hit_s ? S_DONE : S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_valid_i) begin
                    state_d = last_byte_s ? S_DONE : S_REQ;
                end else if (timeout_s) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values; outputs are decoded from state_d
    always_comb begin
        base_d      = base_q;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        shift_d     = shift_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        data_d      = data_q;
        case (state_q)
            S_IDLE: begin
                if (r_enable_i && hit_s) begin
                    data_d = buf_data_q;
                end else if (r_enable_i) begin
                    base_d     = req_base_s;
                    byte_cnt_d = 2'd0;
                end else begin
                    data_d = data_q;
                end
            end
            S_REQ: wait_cnt_d = {WCNT_W{1'b0}};
            S_WAIT: begin
                if (mem_valid_i) begin
                    case (byte_cnt_q)
                        2'd0:    shift_d[7:0]   = mem_data_i;
                        2'd1:    shift_d[15:8]  = mem_data_i;
                        2'd2:    shift_d[23:16] = mem_data_i;
                        2'd3:    shift_d[31:24] = mem_data_i;
                        default: shift_d        = shift_q;
                    endcase
                    if (last_byte_s) begin
                        data_d      = shift_d;
                        buf_addr_d  = base_q;
                        buf_data_d  = shift_d;
                        buf_valid_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (timeout_s) begin
                    wait_cnt_d = {WCNT_W{1'b0}};
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            S_DONE:  data_d = data_q;
            default: data_d = data_q;
        endcase
        // Reload always wins over a buffer fill in the same cycle
        if (invalidate_i) begin
            buf_valid_d = 1'b0;
        end else begin
            buf_valid_d = buf_valid_d;
        end
        mem_re_d = (state_d == S_REQ);
        busy_d   = (state_d == S_REQ) || (state_d == S_WAIT);
        done_d   = (state_d == S_DONE);
        if (state_d == S_REQ) begin
            mem_addr_d = base_d | ADDR_W'(byte_cnt_d);
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            byte_cnt_q  <= 2'd0;
            wait_cnt_q  <= '0;
            shift_q     <= '0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
        end else begin
            base_q      <= base_d;
            byte_cnt_q  <= byte_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            shift_q     <= shift_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            buf_valid_q <= buf_valid_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_re_o   = mem_re_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a cycle-stepped byte-memory responder.
module tb_rom_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_enable_i;
    logic [31:0] addr_i;
    logic [31:0] data_o;
    logic        busy_o;
    logic        done_o;
    logic        invalidate_i;
    logic [31:0] mem_addr_o;
    logic        mem_re_o;
    logic [7:0]  mem_data_i;
    logic        mem_valid_i;

    int total = 0;
    int bad   = 0;

    int          res_cycles;
    int          res_re;
    int          res_done;
    logic [31:0] res_data;
    logic [31:0] re_addr [0:7];
    int          re_cyc  [0:7];

    rom_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .r_enable_i   (r_enable_i),
        .addr_i       (addr_i),
        .data_o       (data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .invalidate_i (invalidate_i),
        .mem_addr_o   (mem_addr_o),
        .mem_re_o     (mem_re_o),
        .mem_data_i   (mem_data_i),
        .mem_valid_i  (mem_valid_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One IF request; memory answers each byte read 'lat' idle cycles after the strobe,
    // except the first read of byte 'hold_byte', which is never answered.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] word, input int lat,
                            input int hold_byte, input bit disturb, input bit inv_done);
        int   cyc, post, pcnt, bi;
        bit   pending, held, done_seen;
        logic [7:0] pbyte;
        cyc = 0; post = 0; pcnt = 0; pending = 0; held = 0; done_seen = 0; pbyte = 8'h00;
        res_cycles = 0; res_re = 0; res_done = 0; res_data = 32'h0;
        for (int i = 0; i < 8; i++) begin
            re_addr[i] = 32'h0;
            re_cyc[i]  = 0;
        end
        @(negedge clk);
        r_enable_i = 1'b1;
        addr_i     = a;
        while (cyc < 2000 && post < 3) begin
            @(negedge clk);
            cyc++;
            mem_valid_i  = 1'b0;
            invalidate_i = 1'b0;
            if (done_seen) post++;
            if (done_o) begin
                res_done++;
                if (!done_seen) begin
                    res_cycles = cyc;
                    res_data   = data_o;
                    done_seen  = 1'b1;
                    r_enable_i = 1'b0;
                    if (inv_done) invalidate_i = 1'b1;
                end
            end
            if (pending) begin
                if (pcnt == 0) begin
                    mem_valid_i = 1'b1;
                    mem_data_i  = pbyte;
                    pending     = 1'b0;
                end else begin
                    pcnt--;
                end
            end
            if (mem_re_o) begin
                if (res_re < 8) begin
                    re_addr[res_re] = mem_addr_o;
                    re_cyc[res_re]  = cyc;
                end
                res_re++;
                bi = int'(mem_addr_o[1:0]);
                if (bi == hold_byte && !held) begin
                    held = 1'b1;
                end else begin
                    pending = 1'b1;
                    pcnt    = lat;
                    pbyte   = word[8*bi +: 8];
                end
            end
            if (disturb && res_re >= 1 && !done_seen) begin
                r_enable_i = ~r_enable_i;
                addr_i     = 32'h0000_0200;
            end
        end
        r_enable_i   = 1'b0;
        invalidate_i = 1'b0;
        if (!done_seen) check_eq("fetch_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; r_enable_i = 1'b0; addr_i = 32'h0; invalidate_i = 1'b0;
        mem_data_i = 8'h00; mem_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", data_o, 32'h0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_re",   {31'd0, mem_re_o}, 32'd0);
        check_eq("rst_maddr", mem_addr_o, 32'h0);
        rst = 1'b0;

        // Test 1: reset while waiting on a byte
        @(negedge clk);
        r_enable_i = 1'b1; addr_i = 32'h0000_0300;
        n = 0;
        while (!mem_re_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("t1_reached_req", {31'd0, mem_re_o}, 32'd1);
        r_enable_i = 1'b0;
        @(negedge clk);
        check_eq("t1_in_wait_busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("t1_busy", {31'd0, busy_o}, 32'd0);
        check_eq("t1_done", {31'd0, done_o}, 32'd0);
        check_eq("t1_re",   {31'd0, mem_re_o}, 32'd0);
        check_eq("t1_maddr", mem_addr_o, 32'h0);
        check_eq("t1_data", data_o, 32'h0);
        mem_valid_i = 1'b1; mem_data_i = 8'hAA;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_valid_i = 1'b0;
            if (done_o || busy_o) n++;
        end
        check_eq("t1_late_valid", n, 32'd0);

        // Test 2: miss at 0x104 with slow memory
        do_fetch(32'h0000_0104, 32'h0050_0513, 2, -1, 1'b0, 1'b0);
        check_eq("t2_data", res_data, 32'h0050_0513);
        check_eq("t2_done_cnt", res_done, 32'd1);
        check_eq("t2_re_cnt", res_re, 32'd4);
        for (int i = 0; i < 4; i++) check_eq("t2_maddr", re_addr[i], 32'h0000_0104 + i);
        check_eq("t2_data_held", data_o, 32'h0050_0513);

        // Test 3: replay from the last-word buffer
        do_fetch(32'h0000_0106, 32'hFFFF_FFFF, 0, -1, 1'b0, 1'b0);
        check_eq("t3_latency", res_cycles, 32'd1);
        check_eq("t3_re_cnt", res_re, 32'd0);
        check_eq("t3_data", res_data, 32'h0050_0513);
        check_eq("t3_done_cnt", res_done, 32'd1);

        // Test 4: invalidate before and during DONE
        @(negedge clk); invalidate_i = 1'b1;
        @(negedge clk); invalidate_i = 1'b0;
        do_fetch(32'h0000_0104, 32'h0050_0513, 1, -1, 1'b0, 1'b1);
        check_eq("t4_miss_re", res_re, 32'd4);
        check_eq("t4_data", res_data, 32'h0050_0513);
        do_fetch(32'h0000_0104, 32'h0050_0513, 0, -1, 1'b0, 1'b0);
        check_eq("t4_inv_done_re", res_re, 32'd4);
        do_fetch(32'h0000_0104, 32'hFFFF_FFFF, 0, -1, 1'b0, 1'b0);
        check_eq("t4_refill_hit_re", res_re, 32'd0);
        check_eq("t4_refill_hit_data", res_data, 32'h0050_0513);

        // Test 5: byte 2 unanswered until the re-issue
        do_fetch(32'h0000_0108, 32'hA1B2_C3D4, 1, 2, 1'b0, 1'b0);
        check_eq("t5_re_cnt", res_re, 32'd5);
        check_eq("t5_first_b2", re_addr[2], 32'h0000_010A);
        check_eq("t5_retry_b2", re_addr[3], 32'h0000_010A);
        check_eq("t5_b3", re_addr[4], 32'h0000_010B);
        check_eq("t5_retry_gap", re_cyc[3] - re_cyc[2], 32'd256);
        check_eq("t5_data", res_data, 32'hA1B2_C3D4);

        // Test 6: request lines wiggle mid-fetch
        do_fetch(32'h0000_010C, 32'h1122_3344, 1, -1, 1'b1, 1'b0);
        check_eq("t6_data", res_data, 32'h1122_3344);
        check_eq("t6_re_cnt", res_re, 32'd4);
        check_eq("t6_b0", re_addr[0], 32'h0000_010C);
        check_eq("t6_b3", re_addr[3], 32'h0000_010F);
        check_eq("t6_done_cnt", res_done, 32'd1);
        do_fetch(32'h0000_0200, 32'hCAFE_F00D, 0, -1, 1'b0, 1'b0);
        check_eq("t6_next_addr", re_addr[0], 32'h0000_0200);
        check_eq("t6_next_data", res_data, 32'hCAFE_F00D);

        // Zero-latency miss: done pulse in the tenth cycle counting the accept cycle
        do_fetch(32'h0000_0400, 32'h0BAD_F00D, 0, -1, 1'b0, 1'b0);
        check_eq("zl_latency", res_cycles, 32'd9);
        check_eq("zl_data", res_data, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
